// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - forwarding select and hazard stall controller
// Tracks in-flight destination registers per back-end stage and resolves ID operand sources.
module fwd_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 32,
    localparam int SELW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic                      id_kill,
    input  logic                      id_wen,
    input  logic                      id_is_load,
    input  logic [4:0]                id_rd,
    input  logic [NUM_SRC*5-1:0]      id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic                      hold,
    output logic                      stall,
    output logic [NUM_SRC*SELW-1:0]   fw_sel,
    output logic [CNT_W-1:0]          stall_count
);

    logic [DEPTH-1:0]  r_valid;
    logic [4:0]        r_rd      [DEPTH];
    logic [DEPTH-1:0]  r_is_load;
    logic [CNT_W-1:0]  r_count;

    logic                     w_hazard;
    logic                     w_push;
    logic                     w_count_en;
    logic [NUM_SRC*SELW-1:0]  w_sel;

    // Scan oldest to youngest so the youngest matching entry is the last one written.
    always_comb begin
        logic       v_found;
        logic       v_ready;
        logic [4:0] v_rs;
        w_sel    = '0;
        w_hazard = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            v_found = 1'b0;
            v_ready = 1'b0;
            v_rs    = id_rs[k*5 +: 5];
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (r_valid[i] && (r_rd[i] == v_rs) && (v_rs != 5'd0) && id_rs_used[k]) begin
                    v_found = 1'b1;
                    v_ready = !r_is_load[i] || (i >= LOAD_STAGE);
                    w_sel[k*SELW +: SELW] = v_ready ? SELW'(i + 1) : '0;
                end
            end
            if (v_found && !v_ready) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign w_push     = id_valid && !id_kill && !w_hazard && id_wen && (id_rd != 5'd0);
    assign w_count_en = id_valid && !id_kill && w_hazard && !hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (!hold) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                r_valid[i] <= r_valid[i-1];
            end
            r_valid[0] <= w_push;
        end
    end

    always_ff @(posedge clk) begin
        if (!hold) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                r_rd[i]      <= r_rd[i-1];
                r_is_load[i] <= r_is_load[i-1];
            end
            r_rd[0]      <= id_rd;
            r_is_load[0] <= id_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_count_en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign stall       = hold || (id_valid && !id_kill && w_hazard);
    assign fw_sel      = w_sel;
    assign stall_count = r_count;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;

    localparam int NS = 2;
    localparam int D  = 3;
    localparam int LS = 1;
    localparam int SW = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic            id_kill = 1'b0;
    logic            id_wen = 1'b0;
    logic            id_is_load = 1'b0;
    logic [4:0]      id_rd = '0;
    logic [NS*5-1:0] id_rs = '0;
    logic [NS-1:0]   id_rs_used = '0;
    logic            hold = 1'b0;

    logic            stall, stall_s;
    logic [NS*SW-1:0] fw_sel, fw_sel_s;
    logic [31:0]     stall_count;
    logic [1:0]      stall_count_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fwd_scoreboard #(.NUM_SRC(NS), .DEPTH(D), .LOAD_STAGE(LS), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill), .id_wen(id_wen),
        .id_is_load(id_is_load), .id_rd(id_rd), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .hold(hold), .stall(stall), .fw_sel(fw_sel), .stall_count(stall_count)
    );

    fwd_scoreboard #(.NUM_SRC(NS), .DEPTH(D), .LOAD_STAGE(LS), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill), .id_wen(id_wen),
        .id_is_load(id_is_load), .id_rd(id_rd), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .hold(hold), .stall(stall_s), .fw_sel(fw_sel_s), .stall_count(stall_count_s)
    );

    // Reference: list of in-flight writers, index 0 = youngest stage.
    typedef struct { bit v; bit [4:0] rd; bit ld; } ent_t;
    ent_t   m_q[$];
    longint m_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_out(output bit st, output bit [NS*SW-1:0] sel, output bit hz);
        sel = '0;
        hz  = 1'b0;
        for (int k = 0; k < NS; k++) begin
            int hit = -1;
            bit [4:0] rs = id_rs[k*5 +: 5];
            for (int j = 0; j < D; j++) begin
                if (hit < 0 && m_q[j].v && m_q[j].rd == rs && rs != 0 && id_rs_used[k]) hit = j;
            end
            if (hit >= 0) begin
                if (!m_q[hit].ld || hit >= LS) sel[k*SW +: SW] = SW'(hit + 1);
                else hz = 1'b1;
            end
        end
        st = hold || (id_valid && !id_kill && hz);
    endfunction

    task automatic eval();
        bit st, hz;
        bit [NS*SW-1:0] sel;
        longint cap;
        @(negedge clk);
        model_out(st, sel, hz);
        check("stall", 64'(stall), 64'(st));
        check("fw_sel", 64'(fw_sel), 64'(sel));
        cap = (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt;
        check("stall_count", 64'(stall_count), 64'(cap));
        check("stall_count_sat", 64'(stall_count_s), 64'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    task automatic adv();
        bit st, hz;
        bit [NS*SW-1:0] sel;
        ent_t e;
        @(posedge clk);
        model_out(st, sel, hz);
        if (rst) begin
            foreach (m_q[j]) m_q[j].v = 1'b0;
            m_cnt = 0;
        end else begin
            if (id_valid && !id_kill && hz && !hold) m_cnt++;
            if (!hold) begin
                e.v  = id_valid && !id_kill && !hz && id_wen && id_rd != 0;
                e.rd = id_rd;
                e.ld = id_is_load;
                m_q.push_front(e);
                void'(m_q.pop_back());
            end
        end
        #1;
    endtask

    task automatic set_id(input bit v, input bit kl, input bit we, input bit ld, input bit [4:0] rd,
                          input bit [4:0] rs0, input bit [4:0] rs1, input bit [1:0] used);
        id_valid = v; id_kill = kl; id_wen = we; id_is_load = ld; id_rd = rd;
        id_rs = {rs1, rs0}; id_rs_used = used;
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    initial begin
        ent_t z;
        z.v = 0; z.rd = 0; z.ld = 0;
        for (int j = 0; j < D; j++) m_q.push_back(z);

        // Reset with random inputs
        rst = 1'b1;
        set_id(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
               5'($urandom), 5'($urandom), 2'($urandom));
        adv();
        step();
        rst = 1'b0; hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        eval();
        check("rst_count", 64'(stall_count), 0);
        check("rst_fw", 64'(fw_sel), 0);
        check("rst_stall", 64'(stall), 64'(hold));
        adv();

        // ALU chain on x5
        set_id(1, 0, 1, 0, 5, 0, 0, 2'b00); step();
        set_id(1, 0, 0, 0, 0, 5, 0, 2'b01); eval();
        check("alu_fw1", 64'(fw_sel), 1);
        check("alu_nostall", 64'(stall), 0);
        adv();
        eval(); check("alu_fw2", 64'(fw_sel), 2); adv();
        eval(); adv();
        eval(); check("alu_retired", 64'(fw_sel), 0); adv();

        // Load-use on x6 via source 1
        set_id(1, 0, 1, 1, 6, 0, 0, 2'b00); step();
        set_id(1, 0, 0, 0, 0, 0, 6, 2'b10); eval();
        check("lu_stall", 64'(stall), 1);
        check("lu_fw0", 64'(fw_sel), 0);
        adv();
        eval();
        check("lu_go", 64'(stall), 0);
        check("lu_fw2", 64'(fw_sel), 64'(2 << SW));
        check("lu_count", 64'(stall_count), 1);
        adv();

        // Youngest wins, and x0 never matches
        set_id(1, 0, 1, 0, 7, 0, 0, 2'b00); step(); step();
        set_id(1, 0, 0, 0, 0, 7, 7, 2'b11); eval();
        check("young_fw", 64'(fw_sel), 64'((1 << SW) | 1));
        adv();
        set_id(1, 0, 1, 0, 0, 0, 0, 2'b00); step();
        set_id(1, 0, 0, 0, 0, 0, 0, 2'b11); eval();
        check("x0_fw", 64'(fw_sel), 0);
        check("x0_stall", 64'(stall), 0);
        adv();

        // Hold with load in entry 0 and consumer waiting
        set_id(1, 0, 1, 1, 9, 0, 0, 2'b00); step();
        set_id(1, 0, 0, 0, 0, 9, 0, 2'b01);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            eval(); check("hold_stall", 64'(stall), 1); check("hold_count", 64'(stall_count), 1); adv();
        end
        hold = 1'b0;
        eval(); check("post_hold_stall", 64'(stall), 1); adv();
        eval(); check("post_hold_fw", 64'(fw_sel), 2); check("post_hold_cnt", 64'(stall_count), 2); adv();

        // Killed consumer of a load
        set_id(1, 0, 1, 1, 10, 0, 0, 2'b00); step();
        set_id(1, 1, 1, 0, 12, 10, 0, 2'b01); eval();
        check("kill_stall", 64'(stall), 0);
        adv();
        set_id(1, 0, 0, 0, 0, 12, 0, 2'b01); eval();
        check("kill_nopush", 64'(fw_sel), 0);
        check("kill_nocount", 64'(stall_count), 2);
        adv();

        // Saturation of the 2-bit counter
        for (int c = 0; c < 5; c++) begin
            set_id(1, 0, 1, 1, 11, 0, 0, 2'b00); step();
            set_id(1, 0, 0, 0, 0, 11, 0, 2'b01); step(); step();
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        eval(); check("sat_hold3", 64'(stall_count_s), 3); check("wide_count", 64'(stall_count), 7); adv();

        // Randomized traffic over a small register window
        for (int c = 0; c < 600; c++) begin
            rst  = ($urandom_range(0, 99) < 2);
            hold = ($urandom_range(0, 99) < 20);
            set_id(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 10), 1'($urandom),
                   ($urandom_range(0, 99) < 35), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom));
            step();
        end
        rst = 1'b0; hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
